// File: rtl/peripheral_dbg_soc_osd_mam_bb_arbiter.sv
// Two-requester arbiter for a MAM-style memory-access port in front of the bus-bridge adapter.
// A grant covers a whole transaction (request plus every data beat), so beats never interleave.
module peripheral_dbg_soc_osd_mam_bb_arbiter #(
  parameter int XLEN = 16,
  parameter int PLEN = 32,
  parameter int FAIR = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_we,
  input  logic [PLEN-1:0]   r0_req_addr,
  input  logic              r0_req_burst,
  input  logic [12:0]       r0_req_beats,
  input  logic              r0_req_sync,
  input  logic              r0_write_valid,
  input  logic [XLEN-1:0]   r0_write_data,
  input  logic [XLEN/8-1:0] r0_write_strb,
  output logic              r0_write_ready,
  output logic              r0_write_complete,
  output logic              r0_read_valid,
  output logic [XLEN-1:0]   r0_read_data,
  input  logic              r0_read_ready,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_we,
  input  logic [PLEN-1:0]   r1_req_addr,
  input  logic              r1_req_burst,
  input  logic [12:0]       r1_req_beats,
  input  logic              r1_req_sync,
  input  logic              r1_write_valid,
  input  logic [XLEN-1:0]   r1_write_data,
  input  logic [XLEN/8-1:0] r1_write_strb,
  output logic              r1_write_ready,
  output logic              r1_write_complete,
  output logic              r1_read_valid,
  output logic [XLEN-1:0]   r1_read_data,
  input  logic              r1_read_ready,

  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_we,
  output logic [PLEN-1:0]   m_req_addr,
  output logic              m_req_burst,
  output logic [12:0]       m_req_beats,
  output logic              m_req_sync,
  output logic              m_write_valid,
  output logic [XLEN-1:0]   m_write_data,
  output logic [XLEN/8-1:0] m_write_strb,
  input  logic              m_write_ready,
  input  logic              m_write_complete,
  input  logic              m_read_valid,
  input  logic [XLEN-1:0]   m_read_data,
  output logic              m_read_ready,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [12:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        beat_hs;

  logic        sel_req_valid, sel_req_burst, sel_write_valid, sel_read_ready;
  logic [12:0] sel_req_beats;

  // Payload paths follow the owner unconditionally; only the handshakes are gated by the FSM.
  assign sel_req_valid   = owner_q ? r1_req_valid   : r0_req_valid;
  assign sel_req_burst   = owner_q ? r1_req_burst   : r0_req_burst;
  assign sel_req_beats   = owner_q ? r1_req_beats   : r0_req_beats;
  assign sel_write_valid = owner_q ? r1_write_valid : r0_write_valid;
  assign sel_read_ready  = owner_q ? r1_read_ready  : r0_read_ready;

  assign m_req_we     = owner_q ? r1_req_we     : r0_req_we;
  assign m_req_addr   = owner_q ? r1_req_addr   : r0_req_addr;
  assign m_req_burst  = sel_req_burst;
  assign m_req_beats  = sel_req_beats;
  assign m_req_sync   = owner_q ? r1_req_sync   : r0_req_sync;
  assign m_write_data = owner_q ? r1_write_data : r0_write_data;
  assign m_write_strb = owner_q ? r1_write_strb : r0_write_strb;
  assign r0_read_data = m_read_data;
  assign r1_read_data = m_read_data;

  assign grant_o = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_d            = last_q;
    cnt_d             = cnt_q;
    we_d              = we_q;
    beat_hs           = 1'b0;
    m_req_valid       = 1'b0;
    m_write_valid     = 1'b0;
    m_read_ready      = 1'b0;
    r0_req_ready      = 1'b0;
    r1_req_ready      = 1'b0;
    r0_write_ready    = 1'b0;
    r1_write_ready    = 1'b0;
    r0_read_valid     = 1'b0;
    r1_read_valid     = 1'b0;
    r0_write_complete = 1'b0;
    r1_write_complete = 1'b0;

    case (state_q)
      IDLE: begin
        // last_q holds the previous owner, so a tie goes to the other requester when fair.
        if (r0_req_valid || r1_req_valid) begin
          state_d = REQ;
          if (r0_req_valid && r1_req_valid)
            owner_d = (FAIR != 0) ? ~last_q : 1'b0;
          else
            owner_d = r1_req_valid;
        end
      end
      REQ: begin
        m_req_valid  = sel_req_valid;
        r0_req_ready = !owner_q && m_req_ready;
        r1_req_ready = owner_q && m_req_ready;
        if (sel_req_valid && m_req_ready) begin
          cnt_d   = (sel_req_burst && sel_req_beats != 13'd0) ? sel_req_beats : 13'd1;
          we_d    = m_req_we;
          state_d = DATA;
        end
      end
      DATA: begin
        if (we_q) begin
          m_write_valid  = sel_write_valid;
          r0_write_ready = !owner_q && m_write_ready;
          r1_write_ready = owner_q && m_write_ready;
          beat_hs        = sel_write_valid && m_write_ready;
        end else begin
          m_read_ready  = sel_read_ready;
          r0_read_valid = !owner_q && m_read_valid;
          r1_read_valid = owner_q && m_read_valid;
          beat_hs       = m_read_valid && sel_read_ready;
        end
        if (beat_hs) begin
          if (cnt_q == 13'd1) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 13'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      r0_write_complete = !owner_q && m_write_complete;
      r1_write_complete = owner_q && m_write_complete;
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_mam_bb_arbiter.sv
// Scoreboard bench for the MAM bus-bridge arbiter: stimulus pushes expected transfers,
// a negedge monitor pops and compares them; a FAIR=0 twin checks fixed-priority grants.
module tb_peripheral_dbg_soc_osd_mam_bb_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        r0_req_valid = 0, r0_req_we = 0, r0_req_burst = 0, r0_req_sync = 0;
  logic [31:0] r0_req_addr = 0;
  logic [12:0] r0_req_beats = 0;
  logic        r0_write_valid = 0, r0_read_ready = 0;
  logic [15:0] r0_write_data = 0;
  logic [1:0]  r0_write_strb = 0;
  logic        r1_req_valid = 0, r1_req_we = 0, r1_req_burst = 0, r1_req_sync = 0;
  logic [31:0] r1_req_addr = 0;
  logic [12:0] r1_req_beats = 0;
  logic        r1_write_valid = 0, r1_read_ready = 0;
  logic [15:0] r1_write_data = 0;
  logic [1:0]  r1_write_strb = 0;
  logic        m_req_ready = 0, m_write_ready = 0, m_write_complete = 0, m_read_valid = 0;
  logic [15:0] m_read_data = 0;

  logic        r0_req_ready, r0_write_ready, r0_write_complete, r0_read_valid;
  logic [15:0] r0_read_data;
  logic        r1_req_ready, r1_write_ready, r1_write_complete, r1_read_valid;
  logic [15:0] r1_read_data;
  logic        m_req_valid, m_req_we, m_req_burst, m_req_sync, m_write_valid, m_read_ready;
  logic [31:0] m_req_addr;
  logic [12:0] m_req_beats;
  logic [15:0] m_write_data;
  logic [1:0]  m_write_strb, grant_o;

  logic        f_r0_req_ready, f_r0_write_ready, f_r0_write_complete, f_r0_read_valid;
  logic [15:0] f_r0_read_data;
  logic        f_r1_req_ready, f_r1_write_ready, f_r1_write_complete, f_r1_read_valid;
  logic [15:0] f_r1_read_data;
  logic        f_m_req_valid, f_m_req_we, f_m_req_burst, f_m_req_sync, f_m_write_valid, f_m_read_ready;
  logic [31:0] f_m_req_addr;
  logic [12:0] f_m_req_beats;
  logic [15:0] f_m_write_data;
  logic [1:0]  f_m_write_strb, f_grant_o;

  peripheral_dbg_soc_osd_mam_bb_arbiter #(.XLEN(16), .PLEN(32), .FAIR(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_burst(r0_req_burst), .r0_req_beats(r0_req_beats),
    .r0_req_sync(r0_req_sync), .r0_write_valid(r0_write_valid), .r0_write_data(r0_write_data),
    .r0_write_strb(r0_write_strb), .r0_write_ready(r0_write_ready),
    .r0_write_complete(r0_write_complete), .r0_read_valid(r0_read_valid),
    .r0_read_data(r0_read_data), .r0_read_ready(r0_read_ready),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_burst(r1_req_burst), .r1_req_beats(r1_req_beats),
    .r1_req_sync(r1_req_sync), .r1_write_valid(r1_write_valid), .r1_write_data(r1_write_data),
    .r1_write_strb(r1_write_strb), .r1_write_ready(r1_write_ready),
    .r1_write_complete(r1_write_complete), .r1_read_valid(r1_read_valid),
    .r1_read_data(r1_read_data), .r1_read_ready(r1_read_ready),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
    .m_req_sync(m_req_sync), .m_write_valid(m_write_valid), .m_write_data(m_write_data),
    .m_write_strb(m_write_strb), .m_write_ready(m_write_ready),
    .m_write_complete(m_write_complete), .m_read_valid(m_read_valid),
    .m_read_data(m_read_data), .m_read_ready(m_read_ready), .grant_o(grant_o)
  );

  peripheral_dbg_soc_osd_mam_bb_arbiter #(.XLEN(16), .PLEN(32), .FAIR(0)) dut_fixed (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_req_valid(r0_req_valid), .r0_req_ready(f_r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_burst(r0_req_burst), .r0_req_beats(r0_req_beats),
    .r0_req_sync(r0_req_sync), .r0_write_valid(r0_write_valid), .r0_write_data(r0_write_data),
    .r0_write_strb(r0_write_strb), .r0_write_ready(f_r0_write_ready),
    .r0_write_complete(f_r0_write_complete), .r0_read_valid(f_r0_read_valid),
    .r0_read_data(f_r0_read_data), .r0_read_ready(r0_read_ready),
    .r1_req_valid(r1_req_valid), .r1_req_ready(f_r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_burst(r1_req_burst), .r1_req_beats(r1_req_beats),
    .r1_req_sync(r1_req_sync), .r1_write_valid(r1_write_valid), .r1_write_data(r1_write_data),
    .r1_write_strb(r1_write_strb), .r1_write_ready(f_r1_write_ready),
    .r1_write_complete(f_r1_write_complete), .r1_read_valid(f_r1_read_valid),
    .r1_read_data(f_r1_read_data), .r1_read_ready(r1_read_ready),
    .m_req_valid(f_m_req_valid), .m_req_ready(m_req_ready), .m_req_we(f_m_req_we),
    .m_req_addr(f_m_req_addr), .m_req_burst(f_m_req_burst), .m_req_beats(f_m_req_beats),
    .m_req_sync(f_m_req_sync), .m_write_valid(f_m_write_valid), .m_write_data(f_m_write_data),
    .m_write_strb(f_m_write_strb), .m_write_ready(m_write_ready),
    .m_write_complete(m_write_complete), .m_read_valid(m_read_valid),
    .m_read_data(m_read_data), .m_read_ready(f_m_read_ready), .grant_o(f_grant_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] req_q[$], wr_q[$], rd_q[$], g_q[$], g1_q[$];
  logic [1:0]  prev_grant = 0, prev_grant_f = 0;
  logic        fixed_en = 0;
  int          wr_hs = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out or unexpected event", name);
  endtask

  // Monitor: every handshake the DUT presents is matched against the next expected entry.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_req_valid && m_req_ready) begin
        if (req_q.size() == 0) fail_now("req_unexpected");
        else checkOutput("req", {15'b0, grant_o[1], m_req_we, m_req_addr, m_req_burst,
                                 m_req_beats, m_req_sync}, req_q.pop_front());
      end
      if (m_write_valid && m_write_ready) begin
        wr_hs++;
        if (wr_q.size() == 0) fail_now("write_unexpected");
        else checkOutput("write_beat", {45'b0, grant_o[1], m_write_data, m_write_strb},
                         wr_q.pop_front());
      end
      if (r0_read_valid && r0_read_ready) begin
        if (rd_q.size() == 0) fail_now("r0_read_unexpected");
        else checkOutput("r0_read", {47'b0, 1'b0, r0_read_data}, rd_q.pop_front());
      end
      if (r1_read_valid && r1_read_ready) begin
        if (rd_q.size() == 0) fail_now("r1_read_unexpected");
        else checkOutput("r1_read", {47'b0, 1'b1, r1_read_data}, rd_q.pop_front());
      end
      if (grant_o != 2'b00 && prev_grant == 2'b00) begin
        if (g_q.size() == 0) fail_now("grant_unexpected");
        else checkOutput("grant", {62'b0, grant_o}, g_q.pop_front());
      end
      if (fixed_en && f_grant_o != 2'b00 && prev_grant_f == 2'b00) begin
        if (g1_q.size() == 0) fail_now("fixed_grant_unexpected");
        else checkOutput("fixed_grant", {62'b0, f_grant_o}, g1_q.pop_front());
      end
    end
    prev_grant   = grant_o;
    prev_grant_f = f_grant_o;
  end

  function automatic logic [11:0] ctl_outputs();
    return {r0_req_ready, r0_write_ready, r0_write_complete, r0_read_valid,
            r1_req_ready, r1_write_ready, r1_write_complete, r1_read_valid,
            m_req_valid, m_write_valid, m_read_ready, |grant_o};
  endfunction

  task automatic set_req(input int r, input logic v, input logic we, input logic [31:0] a,
                         input logic burst, input logic [12:0] beats, input logic sync);
    if (r == 0) begin
      r0_req_valid = v; r0_req_we = we; r0_req_addr = a;
      r0_req_burst = burst; r0_req_beats = beats; r0_req_sync = sync;
    end else begin
      r1_req_valid = v; r1_req_we = we; r1_req_addr = a;
      r1_req_burst = burst; r1_req_beats = beats; r1_req_sync = sync;
    end
  endtask

  // Raises a request and records the grant and the forwarded request it must produce.
  task automatic applyStimulus(input int r, input logic we, input logic [31:0] a, input logic burst,
                               input logic [12:0] beats, input logic sync, input logic [1:0] g);
    logic rb;
    rb = (r != 0);
    g_q.push_back({62'b0, g});
    req_q.push_back({15'b0, rb, we, a, burst, beats, sync});
    set_req(r, 1'b1, we, a, burst, beats, sync);
  endtask

  task automatic wait_req_hs(input int r);
    bit found;
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk_i);
      if (m_req_valid && m_req_ready) found = 1;
    end
    if (!found) fail_now("req_handshake_timeout");
    @(posedge clk_i); #1;
    if (r == 0) r0_req_valid = 0; else r1_req_valid = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    m_write_complete = 1; m_read_valid = 1; r0_read_ready = 1; r1_read_ready = 1;
    repeat (2) @(posedge clk_i);
    #1 checkOutput("reset_outputs", {52'b0, ctl_outputs()}, 64'd0);
    m_write_complete = 0; m_read_valid = 0; r0_read_ready = 0; r1_read_ready = 0;
    rst_i = 0;
  endtask

  task automatic read_beats(input int r, input int n, input logic [15:0] base);
    bit done;
    r0_read_ready = 1; r1_read_ready = 1;
    for (int i = 0; i < n; i++) begin
      m_read_valid = 1;
      m_read_data  = base + 16'(i);
      rd_q.push_back({47'b0, (r != 0), m_read_data});
      done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
        @(negedge clk_i);
        checkOutput("nonowner_read_valid", {63'b0, (r == 0) ? r1_read_valid : r0_read_valid}, 64'd0);
        if ((r == 0) ? r0_read_valid : r1_read_valid) done = 1;
        @(posedge clk_i); #1;
      end
      if (!done) fail_now("read_beat_timeout");
    end
    m_read_valid = 0;
    r0_read_ready = 0; r1_read_ready = 0;
  endtask

  task automatic write_beats(input int r, input int n, input logic [15:0] base, input bit toggle,
                             input bit complete);
    bit done;
    logic [15:0] d;
    logic [1:0]  s;
    m_write_ready = toggle ? 1'b0 : 1'b1;
    for (int i = 0; i < n; i++) begin
      d = base + 16'(i);
      s = (i % 2 == 1) ? 2'b10 : 2'b01;
      if (r == 0) begin r0_write_valid = 1; r0_write_data = d; r0_write_strb = s; end
      else begin r1_write_valid = 1; r1_write_data = d; r1_write_strb = s; end
      wr_q.push_back({45'b0, (r != 0), d, s});
      m_write_complete = complete && (i == n - 1);
      done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
        @(negedge clk_i);
        checkOutput("nonowner_write_ready", {63'b0, (r == 0) ? r1_write_ready : r0_write_ready}, 64'd0);
        if (m_write_valid && m_write_ready) begin
          done = 1;
          if (m_write_complete)
            checkOutput("write_complete_route", {62'b0, r1_write_complete, r0_write_complete},
                        (r == 0) ? 64'd1 : 64'd2);
        end
        @(posedge clk_i); #1;
        if (toggle) m_write_ready = ~m_write_ready;
      end
      if (!done) fail_now("write_beat_timeout");
    end
    m_write_complete = 0;
    checkOutput("write_after_last", {62'b0, m_write_valid, (r == 0) ? r0_write_ready : r1_write_ready}, 64'd0);
    r0_write_valid = 0; r1_write_valid = 0;
    m_write_ready = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();
    m_req_ready = 1;

    // Single read by r0: one-cycle request latency, one beat, grant returns to idle.
    applyStimulus(0, 1'b0, 32'h100, 1'b0, 13'd0, 1'b0, 2'b01);
    #1 checkOutput("req_latency_idle", {63'b0, m_req_valid}, 64'd0);
    @(posedge clk_i); #1;
    checkOutput("req_latency_req", {61'b0, m_req_valid, grant_o}, 64'b101);
    wait_req_hs(0);
    read_beats(0, 1, 16'hBEEF);
    checkOutput("t1_grant_idle", {62'b0, grant_o}, 64'd0);

    // r1 write burst of 4 with a toggling downstream ready.
    wr_hs = 0;
    applyStimulus(1, 1'b1, 32'h200, 1'b1, 13'd4, 1'b1, 2'b10);
    wait_req_hs(1);
    write_beats(1, 4, 16'hA000, 1'b1, 1'b0);
    checkOutput("t2_handshakes", 64'(wr_hs), 64'd4);
    checkOutput("t2_grant_idle", {62'b0, grant_o}, 64'd0);

    // Simultaneous requests held continuously: FAIR=1 alternates, FAIR=0 keeps r0.
    do_reset();
    m_req_ready = 1;
    fixed_en = 1;
    for (int k = 0; k < 4; k++) begin
      g_q.push_back((k % 2 == 0) ? 64'd1 : 64'd2);
      g1_q.push_back(64'd1);
      req_q.push_back((k % 2 == 0) ? {15'b0, 1'b0, 1'b0, 32'h300, 1'b0, 13'd0, 1'b0}
                                   : {15'b0, 1'b1, 1'b0, 32'h400, 1'b0, 13'd0, 1'b1});
      rd_q.push_back({47'b0, (k % 2 == 1), 16'h1234});
    end
    r0_read_ready = 1; r1_read_ready = 1;
    m_read_valid = 1; m_read_data = 16'h1234;
    set_req(0, 1'b1, 1'b0, 32'h300, 1'b0, 13'd0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h400, 1'b0, 13'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bit found;
      found = 0;
      for (int t = 0; t < 10 && !found; t++) begin
        @(negedge clk_i);
        if (m_req_valid && m_req_ready) found = 1;
      end
      if (!found) fail_now("fair_req_timeout");
    end
    @(posedge clk_i); #1;
    r0_req_valid = 0; r1_req_valid = 0;
    @(posedge clk_i); #1;
    m_read_valid = 0; r0_read_ready = 0; r1_read_ready = 0;
    checkOutput("fixed_grants_consumed", 64'(g1_q.size()), 64'd0);
    fixed_en = 0;

    // Burst with beats=0 behaves as a single beat.
    applyStimulus(0, 1'b0, 32'h500, 1'b1, 13'd0, 1'b0, 2'b01);
    wait_req_hs(0);
    read_beats(0, 1, 16'h5A5A);
    m_read_valid = 1; r0_read_ready = 1;
    #1 checkOutput("t4_idle_after_one", {61'b0, r0_read_valid, m_read_ready, |grant_o}, 64'd0);
    m_read_valid = 0; r0_read_ready = 0;

    // Reset two beats into an 8-beat read, then a fresh r1 single write.
    applyStimulus(0, 1'b0, 32'h600, 1'b1, 13'd8, 1'b0, 2'b01);
    wait_req_hs(0);
    read_beats(0, 2, 16'h6000);
    rst_i = 1;
    @(posedge clk_i); #1;
    m_read_valid = 1; r0_read_ready = 1; r0_write_valid = 1;
    #1 checkOutput("t5_abort_outputs", {52'b0, ctl_outputs()}, 64'd0);
    m_read_valid = 0; r0_read_ready = 0; r0_write_valid = 0;
    rst_i = 0;
    @(posedge clk_i); #1;
    applyStimulus(1, 1'b1, 32'h700, 1'b0, 13'd5, 1'b1, 2'b10);
    wait_req_hs(1);
    write_beats(1, 1, 16'h7700, 1'b0, 1'b0);
    checkOutput("t5_grant_idle", {62'b0, grant_o}, 64'd0);

    // r1 requests while r0's 3-beat write is in progress.
    applyStimulus(0, 1'b1, 32'h800, 1'b1, 13'd3, 1'b0, 2'b01);
    wait_req_hs(0);
    applyStimulus(1, 1'b0, 32'h900, 1'b0, 13'd0, 1'b0, 2'b10);
    #1 checkOutput("t6_r1_waits", {63'b0, r1_req_ready}, 64'd0);
    write_beats(0, 3, 16'hC000, 1'b0, 1'b1);
    checkOutput("t6_idle_gap", {62'b0, grant_o}, 64'd0);
    @(posedge clk_i); #1;
    checkOutput("t6_r1_granted", {62'b0, grant_o}, 64'd2);
    wait_req_hs(1);
    read_beats(1, 1, 16'hD00D);

    repeat (3) @(posedge clk_i);
    checkOutput("queues_empty", 64'(req_q.size() + wr_q.size() + rd_q.size() + g_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
